sign_extend_arb_r0: RTL

Round-robin scheduler that shares one `sign_extend_r0` instance (latency `DELAY`) among `NUM_REQ` requesters, such as the decode immediate, load-byte/half and branch-offset paths of the MIPS core. It accepts one request per cycle and drives the extender's `dataIn` and `is_signed`. It tracks in-flight requests with a tag pipeline and routes each result back to its requester. Because `is_signed` is a single static control on the shared extender, the arbiter drains the pipeline before changing signedness.

---
 rtl/sign_extend_arb_r0.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/sign_extend_arb_r0.sv
// Round-robin share of one sign extender (latency DELAY); grant combinational, result DELAY cycles later, no rsp backpressure.
// Signedness flips only after in-flight work drains; SIGN_EXTEND_ARB_DRAIN_CNT_EN builds the drain-stall counter.
module sign_extend_arb_r0 #(
    parameter int BIT_WIDTH_IN  = 16,
    parameter int BIT_WIDTH_OUT = 32,
    parameter int NUM_REQ       = 4,
    parameter int DELAY         = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_signed,
    input  logic [BIT_WIDTH_IN*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            ext_is_signed,
    output logic [BIT_WIDTH_IN-1:0]         ext_dataIn,
    input  logic [BIT_WIDTH_OUT-1:0]        ext_dataOut,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [BIT_WIDTH_OUT-1:0]        rsp_data,
    output logic [15:0]                     drain_cnt
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [IW-1:0]           lock_q, lock_d;
    logic                    sgn_q, sgn_d;
    logic [BIT_WIDTH_IN-1:0] din_q, din_d;

    logic [IW:0]             sum;
    logic [IW-1:0]           cand;
    logic [IW-1:0]           win_idx;
    logic                    win_found;
    logic                    mismatch;
    logic                    grant;
    logic [BIT_WIDTH_IN-1:0] win_dat;
    logic                    pipe_busy;
    logic                    out_vld;
    logic [IW-1:0]           out_idx;

    // First valid requester scanning upward from ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(NUM_REQ)) begin
                sum = sum - (IW+1)'(NUM_REQ);
            end
            cand = sum[IW-1:0];
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_dat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IW'(i)) begin
                win_dat = req_data[i*BIT_WIDTH_IN +: BIT_WIDTH_IN];
            end
        end
    end

    assign mismatch = win_found && (req_signed[win_idx] != sgn_q);
    assign grant    = !rst && (state_q == RUN) && win_found && !mismatch;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        sgn_d   = sgn_q;
        case (state_q)
            RUN: begin
                if (grant) begin
                    ptr_d = (win_idx == IW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
                end else if (mismatch) begin
                    lock_d = win_idx;
                    // Nothing left to wait for: flip now so the bubble is a single cycle.
                    if (!pipe_busy) begin
                        sgn_d = req_signed[win_idx];
                        ptr_d = win_idx;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!pipe_busy) begin
                    sgn_d   = req_signed[lock_q];
                    ptr_d   = lock_q;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign din_d = ext_dataIn;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            ptr_q   <= '0;
            lock_q  <= '0;
            sgn_q   <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
            sgn_q   <= sgn_d;
            din_q   <= din_d;
        end
    end

    // Tag pipeline; a tag in the last stage is emitting this cycle and does not block a switch.
    generate
        if (DELAY == 0) begin : g_no_pipe
            assign out_vld   = grant;
            assign out_idx   = win_idx;
            assign pipe_busy = 1'b0;
        end else begin : g_pipe
            logic [DELAY-1:0]         tv_q, tv_d;
            logic [DELAY-1:0][IW-1:0] ti_q, ti_d;

            always_comb begin
                tv_d      = '0;
                ti_d      = '0;
                pipe_busy = 1'b0;
                tv_d[0]   = grant;
                ti_d[0]   = win_idx;
                for (int s = 1; s < DELAY; s++) begin
                    tv_d[s] = tv_q[s-1];
                    ti_d[s] = ti_q[s-1];
                end
                for (int s = 0; s < DELAY-1; s++) begin
                    pipe_busy = pipe_busy | tv_q[s];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    tv_q <= '0;
                    ti_q <= '0;
                end else begin
                    tv_q <= tv_d;
                    ti_q <= ti_d;
                end
            end

            assign out_vld = tv_q[DELAY-1];
            assign out_idx = ti_q[DELAY-1];
        end
    endgenerate

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant && (win_idx == IW'(i));
            rsp_valid[i] = !rst && out_vld && (out_idx == IW'(i));
        end
    end

    assign ext_dataIn    = grant ? win_dat : din_q;
    assign ext_is_signed = sgn_q;
    assign rsp_data      = ext_dataOut;

`ifdef SIGN_EXTEND_ARB_DRAIN_CNT_EN
    logic [15:0] drain_cnt_q, drain_cnt_d;

    // The mismatch-detect cycle is itself a stall and is counted.
    always_comb begin
        drain_cnt_d = drain_cnt_q;
        if (((state_q == DRAIN) || ((state_q == RUN) && mismatch)) && (drain_cnt_q != 16'hFFFF)) begin
            drain_cnt_d = drain_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt_q <= '0;
        end else begin
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign drain_cnt = drain_cnt_q;
`else
    assign drain_cnt = 16'h0;
`endif

endmodule
